// File: rtl/ct_l2c_ciu_resp_arb_if.sv
// Response-arbiter bus: two L2C bank write-back streams in, one CIU response channel out.
// slave is the arbiter side; master is the side driving bank completions and CIU ready.
interface ct_l2c_ciu_resp_arb_if;
  logic         bank0_cmplt;
  logic [4:0]   bank0_resp;
  logic [3:0]   bank0_cp;
  logic [4:0]   bank0_sid;
  logic [511:0] bank0_data;
  logic         bank1_cmplt;
  logic [4:0]   bank1_resp;
  logic [3:0]   bank1_cp;
  logic [4:0]   bank1_sid;
  logic [511:0] bank1_data;
  logic         ciu_l2c_resp_rdy;
  logic         l2c_ciu_cmplt;
  logic [4:0]   l2c_ciu_resp;
  logic [3:0]   l2c_ciu_cp;
  logic [4:0]   l2c_ciu_sid;
  logic [511:0] l2c_ciu_data;
  logic         l2c_ciu_bank;
  logic         bank0_resp_stall;
  logic         bank1_resp_stall;
  logic         arb_idle;

  modport slave (
    input  bank0_cmplt, bank0_resp, bank0_cp, bank0_sid, bank0_data,
    input  bank1_cmplt, bank1_resp, bank1_cp, bank1_sid, bank1_data,
    input  ciu_l2c_resp_rdy,
    output l2c_ciu_cmplt, l2c_ciu_resp, l2c_ciu_cp, l2c_ciu_sid, l2c_ciu_data, l2c_ciu_bank,
    output bank0_resp_stall, bank1_resp_stall, arb_idle
  );

  modport master (
    output bank0_cmplt, bank0_resp, bank0_cp, bank0_sid, bank0_data,
    output bank1_cmplt, bank1_resp, bank1_cp, bank1_sid, bank1_data,
    output ciu_l2c_resp_rdy,
    input  l2c_ciu_cmplt, l2c_ciu_resp, l2c_ciu_cp, l2c_ciu_sid, l2c_ciu_data, l2c_ciu_bank,
    input  bank0_resp_stall, bank1_resp_stall, arb_idle
  );
endinterface

// File: rtl/ct_l2c_ciu_resp_arb.sv
// Two-bank L2C-to-CIU response arbiter: per-bank buffers, round-robin pick, lock until accept.
// Optional same-cycle bypass when both buffers are empty: define L2C_RESP_BYPASS_EN.
module ct_l2c_ciu_resp_arb #(
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 2
) (
  input logic                  l2c_clk,
  input logic                  cpurst_b,
  ct_l2c_ciu_resp_arb_if.slave arb_if
);
  localparam int EW = 526;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - PIPE_LAT);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [1:0]         push;
  logic [1:0][EW-1:0] din;
  logic [1:0][EW-1:0] head;
  logic [1:0][CW-1:0] cnt;
  logic [1:0]         nonempty;
  logic [1:0]         wr_en;
  logic [1:0]         pop;
  logic               rr_ptr_q, rr_ptr_d;
  logic               lock_q, lock_d;
  logic               lock_bank_q, lock_bank_d;
  logic               sel, valid, accept, bypass;
  logic [EW-1:0]      sel_entry;

  assign push   = {arb_if.bank1_cmplt, arb_if.bank0_cmplt};
  assign din[0] = {arb_if.bank0_resp, arb_if.bank0_cp, arb_if.bank0_sid, arb_if.bank0_data};
  assign din[1] = {arb_if.bank1_resp, arb_if.bank1_cp, arb_if.bank1_sid, arb_if.bank1_data};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A write into a full buffer is dropped; any pop in the same cycle still proceeds.
    assign wr_en[b]    = push[b] & (cnt_q != FULL_CNT) & ~bypass;
    assign pop[b]      = accept & ~bypass & (sel == 1'(b));
    assign nonempty[b] = (cnt_q != '0);
    assign cnt[b]      = cnt_q;
    assign head[b]     = mem_q[rd_ptr_q];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en[b]) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop[b])   rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(wr_en[b]) - CW'(pop[b]);
    end

    always_ff @(posedge l2c_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge l2c_clk) begin
      if (wr_en[b]) mem_q[wr_ptr_q] <= din[b];
    end
  end

`ifdef L2C_RESP_BYPASS_EN
  assign bypass = (nonempty == 2'b00) & ~lock_q & (push[0] ^ push[1]) & arb_if.ciu_l2c_resp_rdy;
`else
  assign bypass = 1'b0;
`endif

  // A held lock pins the bank so a late push into the preferred bank cannot swap the output.
  always_comb begin
    if (bypass)                 sel = push[1];
    else if (lock_q)            sel = lock_bank_q;
    else if (nonempty[rr_ptr_q]) sel = rr_ptr_q;
    else                        sel = ~rr_ptr_q;
  end

  assign valid     = bypass | lock_q | (|nonempty);
  assign accept    = valid & arb_if.ciu_l2c_resp_rdy;
  assign sel_entry = bypass ? din[sel] : head[sel];

  always_comb begin
    lock_d      = lock_q;
    lock_bank_d = lock_bank_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      lock_d   = 1'b0;
      rr_ptr_d = ~sel;
    end else if (valid) begin
      lock_d      = 1'b1;
      lock_bank_d = sel;
    end
  end

  always_ff @(posedge l2c_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rr_ptr_q    <= 1'b0;
      lock_q      <= 1'b0;
      lock_bank_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_bank_q <= lock_bank_d;
    end
  end

  assign arb_if.l2c_ciu_cmplt = valid;
  assign {arb_if.l2c_ciu_resp, arb_if.l2c_ciu_cp, arb_if.l2c_ciu_sid, arb_if.l2c_ciu_data} =
         valid ? sel_entry : '0;
  assign arb_if.l2c_ciu_bank     = valid & sel;
  assign arb_if.bank0_resp_stall = (cnt[0] >= STALL_CNT);
  assign arb_if.bank1_resp_stall = (cnt[1] >= STALL_CNT);
  assign arb_if.arb_idle         = ~(|nonempty) & ~valid;

endmodule

// File: tb/tb_ct_l2c_ciu_resp_arb.sv
// Scoreboard bench for ct_l2c_ciu_resp_arb: per-bank expected queues popped on every CIU accept.
// A second instance with DEPTH=3 exercises non-power-of-two pointer wrap.
module tb_ct_l2c_ciu_resp_arb;
  localparam int DEPTH = 4;
  localparam int EW    = 526;

  logic l2c_clk  = 1'b0;
  logic cpurst_b = 1'b0;

  ct_l2c_ciu_resp_arb_if arbIf ();
  ct_l2c_ciu_resp_arb_if wrapIf ();

  ct_l2c_ciu_resp_arb #(.DEPTH(4), .PIPE_LAT(2)) dut (
    .l2c_clk (l2c_clk),
    .cpurst_b(cpurst_b),
    .arb_if  (arbIf)
  );

  ct_l2c_ciu_resp_arb #(.DEPTH(3), .PIPE_LAT(1)) dutWrap (
    .l2c_clk (l2c_clk),
    .cpurst_b(cpurst_b),
    .arb_if  (wrapIf)
  );

  always #5 l2c_clk = ~l2c_clk;

  int checkCount = 0;
  int failCount  = 0;
  logic [EW-1:0] expQ0[$];
  logic [EW-1:0] expQ1[$];
  logic [EW-1:0] expWrapQ[$];
  int bankLog[$];

  task automatic checkOutput(input string tag, input logic [EW-1:0] observed,
                             input logic [EW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [EW-1:0] newEntry(input logic [4:0] sid);
    logic [EW-1:0] e;
    e[525:521] = 5'($urandom);
    e[520:517] = 4'($urandom);
    e[516:512] = sid;
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = $urandom;
    return e;
  endfunction

  function automatic logic [EW-1:0] observedEntry();
    return {arbIf.l2c_ciu_resp, arbIf.l2c_ciu_cp, arbIf.l2c_ciu_sid, arbIf.l2c_ciu_data};
  endfunction

  function automatic int logAt(input int i);
    return (i < bankLog.size()) ? bankLog[i] : 3;
  endfunction

  // Drive one cycle of stimulus just after the clock edge, then return at the sampling edge.
  task automatic applyStimulus(input bit p0, input logic [EW-1:0] e0,
                               input bit p1, input logic [EW-1:0] e1, input bit rdy);
    @(posedge l2c_clk); #1;
    arbIf.bank0_cmplt = p0;
    {arbIf.bank0_resp, arbIf.bank0_cp, arbIf.bank0_sid, arbIf.bank0_data} = e0;
    arbIf.bank1_cmplt = p1;
    {arbIf.bank1_resp, arbIf.bank1_cp, arbIf.bank1_sid, arbIf.bank1_data} = e1;
    arbIf.ciu_l2c_resp_rdy = rdy;
    if (p0) begin
      assert (expQ0.size() < DEPTH) else $error("[TB] bank0 write into a full buffer");
      expQ0.push_back(e0);
    end
    if (p1) begin
      assert (expQ1.size() < DEPTH) else $error("[TB] bank1 write into a full buffer");
      expQ1.push_back(e1);
    end
    @(negedge l2c_clk);
  endtask

  task automatic idleCycle(input bit rdy);
    applyStimulus(1'b0, '0, 1'b0, '0, rdy);
  endtask

  task automatic wrapStep(input bit p, input logic [EW-1:0] e, input bit rdy);
    @(posedge l2c_clk); #1;
    wrapIf.bank0_cmplt = p;
    {wrapIf.bank0_resp, wrapIf.bank0_cp, wrapIf.bank0_sid, wrapIf.bank0_data} = e;
    wrapIf.ciu_l2c_resp_rdy = rdy;
    if (p) begin
      assert (expWrapQ.size() < 3) else $error("[TB] wrap bank0 write into a full buffer");
      expWrapQ.push_back(e);
    end
    @(negedge l2c_clk);
  endtask

  task automatic resetDut();
    @(posedge l2c_clk); #1;
    arbIf.bank0_cmplt = 1'b0;
    arbIf.bank1_cmplt = 1'b0;
    arbIf.ciu_l2c_resp_rdy = 1'b0;
    wrapIf.bank0_cmplt = 1'b0;
    wrapIf.ciu_l2c_resp_rdy = 1'b0;
    cpurst_b = 1'b0;
    expQ0.delete();
    expQ1.delete();
    expWrapQ.delete();
    bankLog.delete();
    repeat (2) @(posedge l2c_clk);
    #1 cpurst_b = 1'b1;
  endtask

  // Every accepted response must match the head of its bank's expected queue.
  always @(negedge l2c_clk) begin
    if (cpurst_b && arbIf.l2c_ciu_cmplt && arbIf.ciu_l2c_resp_rdy) begin
      bankLog.push_back(int'(arbIf.l2c_ciu_bank));
      if (arbIf.l2c_ciu_bank == 1'b0) begin
        if (expQ0.size() == 0) checkOutput("unexpectedResp0", EW'(arbIf.l2c_ciu_cmplt), '0);
        else checkOutput("bank0Entry", observedEntry(), expQ0.pop_front());
      end else begin
        if (expQ1.size() == 0) checkOutput("unexpectedResp1", EW'(arbIf.l2c_ciu_cmplt), '0);
        else checkOutput("bank1Entry", observedEntry(), expQ1.pop_front());
      end
    end
  end

  // The DEPTH=3 instance only ever sees bank0 traffic.
  always @(negedge l2c_clk) begin
    if (cpurst_b && wrapIf.l2c_ciu_cmplt && wrapIf.ciu_l2c_resp_rdy) begin
      checkOutput("wrapBank", EW'(wrapIf.l2c_ciu_bank), '0);
      if (expWrapQ.size() == 0) checkOutput("wrapUnexpected", EW'(wrapIf.l2c_ciu_cmplt), '0);
      else checkOutput("wrapEntry",
                       {wrapIf.l2c_ciu_resp, wrapIf.l2c_ciu_cp, wrapIf.l2c_ciu_sid, wrapIf.l2c_ciu_data},
                       expWrapQ.pop_front());
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [EW-1:0] spEntry;
    arbIf.bank0_cmplt = 1'b0;
    arbIf.bank0_resp = '0; arbIf.bank0_cp = '0; arbIf.bank0_sid = '0; arbIf.bank0_data = '0;
    arbIf.bank1_cmplt = 1'b0;
    arbIf.bank1_resp = '0; arbIf.bank1_cp = '0; arbIf.bank1_sid = '0; arbIf.bank1_data = '0;
    arbIf.ciu_l2c_resp_rdy = 1'b0;
    wrapIf.bank0_cmplt = 1'b0;
    wrapIf.bank0_resp = '0; wrapIf.bank0_cp = '0; wrapIf.bank0_sid = '0; wrapIf.bank0_data = '0;
    wrapIf.bank1_cmplt = 1'b0;
    wrapIf.bank1_resp = '0; wrapIf.bank1_cp = '0; wrapIf.bank1_sid = '0; wrapIf.bank1_data = '0;
    wrapIf.ciu_l2c_resp_rdy = 1'b0;

    #2;
    checkOutput("rstCmplt", EW'(arbIf.l2c_ciu_cmplt), '0);
    checkOutput("rstIdle", EW'(arbIf.arb_idle), EW'(1));
    checkOutput("rstStalls", EW'({arbIf.bank1_resp_stall, arbIf.bank0_resp_stall}), '0);
    checkOutput("rstEntry", observedEntry(), '0);
    checkOutput("rstBank", EW'(arbIf.l2c_ciu_bank), '0);
    @(posedge l2c_clk); #1 cpurst_b = 1'b1;

    // Single push: buffered responses appear one cycle later.
    idleCycle(1'b1);
    spEntry = newEntry(5'h03);
    spEntry[525:521] = 5'h01;
    applyStimulus(1'b1, spEntry, 1'b0, '0, 1'b1);
`ifdef L2C_RESP_BYPASS_EN
    checkOutput("spCmpltN", EW'(arbIf.l2c_ciu_cmplt), EW'(1));
    checkOutput("spSidN", EW'(arbIf.l2c_ciu_sid), EW'(5'h03));
`else
    checkOutput("spCmpltN", EW'(arbIf.l2c_ciu_cmplt), '0);
`endif
    idleCycle(1'b1);
`ifndef L2C_RESP_BYPASS_EN
    checkOutput("spCmpltN1", EW'(arbIf.l2c_ciu_cmplt), EW'(1));
    checkOutput("spSidN1", EW'(arbIf.l2c_ciu_sid), EW'(5'h03));
    checkOutput("spRespN1", EW'(arbIf.l2c_ciu_resp), EW'(5'h01));
    checkOutput("spBankN1", EW'(arbIf.l2c_ciu_bank), '0);
`endif
    idleCycle(1'b1);
    checkOutput("spIdleN2", EW'(arbIf.arb_idle), EW'(1));

    // Fairness: three entries per bank, drained alternately from bank 0.
    resetDut();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, newEntry(5'($urandom)), 1'b1, newEntry(5'($urandom)), 1'b0);
    bankLog.delete();
    for (int i = 0; i < 7; i++) idleCycle(1'b1);
    checkOutput("fairCount", EW'(bankLog.size()), EW'(6));
    checkOutput("fairIdle", EW'(arbIf.arb_idle), EW'(1));
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("fairBank%0d", i), EW'(logAt(i)), EW'(i % 2));

    // Backpressure: the presented response holds while ready is low.
    resetDut();
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, newEntry(5'($urandom)), 1'b1, newEntry(5'($urandom)), 1'b0);
    for (int i = 0; i < 5; i++) begin
      idleCycle(1'b0);
      checkOutput($sformatf("holdCmplt%0d", i), EW'(arbIf.l2c_ciu_cmplt), EW'(1));
      checkOutput($sformatf("holdBank%0d", i), EW'(arbIf.l2c_ciu_bank), '0);
      checkOutput($sformatf("holdEntry%0d", i), observedEntry(), expQ0[0]);
    end
    bankLog.delete();
    for (int i = 0; i < 5; i++) idleCycle(1'b1);
    checkOutput("bpCount", EW'(bankLog.size()), EW'(4));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("bpBank%0d", i), EW'(logAt(i)), EW'(i % 2));

    // Stall threshold on bank1, then a lock that survives a push into the preferred bank.
    resetDut();
    applyStimulus(1'b0, '0, 1'b1, newEntry(5'h10), 1'b0);
    checkOutput("stallCnt0", EW'(arbIf.bank1_resp_stall), '0);
    applyStimulus(1'b0, '0, 1'b1, newEntry(5'h11), 1'b0);
    checkOutput("stallCnt1", EW'(arbIf.bank1_resp_stall), '0);
    applyStimulus(1'b0, '0, 1'b1, newEntry(5'h12), 1'b0);
    checkOutput("stallCnt2", EW'(arbIf.bank1_resp_stall), EW'(1));
    applyStimulus(1'b0, '0, 1'b1, newEntry(5'h13), 1'b0);
    checkOutput("stallCnt3", EW'(arbIf.bank1_resp_stall), EW'(1));
    applyStimulus(1'b1, newEntry(5'h01), 1'b0, '0, 1'b0);
    checkOutput("stallCnt4", EW'(arbIf.bank1_resp_stall), EW'(1));
    idleCycle(1'b0);
    checkOutput("lockBank", EW'(arbIf.l2c_ciu_bank), EW'(1));
    checkOutput("lockEntry", observedEntry(), expQ1[0]);
    checkOutput("stallBank0", EW'(arbIf.bank0_resp_stall), '0);
    bankLog.delete();
    for (int i = 0; i < 6; i++) idleCycle(1'b1);
    checkOutput("lockCount", EW'(bankLog.size()), EW'(5));
    checkOutput("lockFirst", EW'(logAt(0)), EW'(1));
    checkOutput("lockSecond", EW'(logAt(1)), '0);

    // Reset mid-operation discards buffered responses immediately.
    resetDut();
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, newEntry(5'($urandom)), 1'b1, newEntry(5'($urandom)), 1'b0);
    @(posedge l2c_clk); #1;
    arbIf.bank0_cmplt = 1'b0;
    arbIf.bank1_cmplt = 1'b0;
    #2 cpurst_b = 1'b0;
    expQ0.delete();
    expQ1.delete();
    #1;
    checkOutput("midRstCmplt", EW'(arbIf.l2c_ciu_cmplt), '0);
    checkOutput("midRstIdle", EW'(arbIf.arb_idle), EW'(1));
    checkOutput("midRstEntry", observedEntry(), '0);
    checkOutput("midRstStall", EW'({arbIf.bank1_resp_stall, arbIf.bank0_resp_stall}), '0);
    repeat (2) @(posedge l2c_clk);
    #1 cpurst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idleCycle(1'b1);
      checkOutput($sformatf("postRstCmplt%0d", i), EW'(arbIf.l2c_ciu_cmplt), '0);
    end

    // DEPTH=3: steady push and pop keeps occupancy at two while pointers wrap.
    resetDut();
    wrapStep(1'b1, newEntry(5'd0), 1'b0);
    wrapStep(1'b1, newEntry(5'd1), 1'b0);
    for (int i = 0; i < 10; i++) begin
      wrapStep(1'b1, newEntry(5'(i + 2)), 1'b1);
      checkOutput($sformatf("wrapStall%0d", i), EW'(wrapIf.bank0_resp_stall), EW'(1));
    end
    wrapStep(1'b0, '0, 1'b1);
    wrapStep(1'b0, '0, 1'b1);
    checkOutput("wrapStallDrop", EW'(wrapIf.bank0_resp_stall), '0);
    wrapStep(1'b0, '0, 1'b1);
    checkOutput("wrapIdle", EW'(wrapIf.arb_idle), EW'(1));

    checkOutput("drainQ0", EW'(expQ0.size()), '0);
    checkOutput("drainQ1", EW'(expQ1.size()), '0);
    checkOutput("drainWrapQ", EW'(expWrapQ.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/ct_l2c_ciu_resp_arb.md
# ct_l2c_ciu_resp_arb

Two-bank response arbiter between the L2C write-back stages and the CIU response channel. Each bank's WB stage delivers completions (resp/cp/sid plus a 512-bit data beat) into a per-bank buffer, because the WB stage cannot stall. The block sequences the buffered responses onto the single CIU channel with round-robin fairness and an accept handshake. It throttles each bank's pipeline early enough that in-flight responses always find a free entry.

## Interface
Parameters:
- DEPTH, 4: entries per bank buffer (legal 3..8).
- PIPE_LAT, 2: responses a bank can still emit after its stall is raised.

Ports:
- l2c_clk  in  1  block clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- bank0_cmplt  in  1  bank 0 response valid (single-cycle, unconditional).
- bank0_resp  in  5  bank 0 response code.
- bank0_cp  in  4  bank 0 coherence/permission bits.
- bank0_sid  in  5  bank 0 source id.
- bank0_data  in  512  bank 0 data beat.
- bank1_cmplt, bank1_resp, bank1_cp, bank1_sid, bank1_data  in  1/5/4/5/512  same fields for bank 1.
- ciu_l2c_resp_rdy  in  1  CIU accepts the presented response this cycle.
- l2c_ciu_cmplt  out  1  response valid.
- l2c_ciu_resp  out  5  selected response code.
- l2c_ciu_cp  out  4  selected cp.
- l2c_ciu_sid  out  5  selected sid.
- l2c_ciu_data  out  512  selected data.
- l2c_ciu_bank  out  1  bank index of the presented response.
- bank0_resp_stall, bank1_resp_stall  out  1  pipeline issue stall per bank.
- arb_idle  out  1  both buffers empty and no response presented.

## Operation
- Per-bank FIFO: DEPTH entries of 526 bits. Write pointer, read pointer, and a count of width clog2(DEPTH+1).
  - A bankN_cmplt write is always accepted.
  - A write into a full FIFO is a design error. The bench flags it with an assertion; the RTL drops the write and holds the FIFO state.
- Stall: bankN_resp_stall = (DEPTH - countN) <= PIPE_LAT.
- Arbitration:
  - rr_ptr names the preferred bank.
  - When no response is locked, select the preferred bank if its FIFO is non-empty, else the other bank.
  - Once l2c_ciu_cmplt is high and rdy is low, the selection is locked. All outputs stay stable until acceptance.
- Accept (cmplt & rdy):
  - Pop the selected FIFO.
  - Set rr_ptr to the other bank.
  - Clear the lock.
- Simultaneous push and pop on the same FIFO: the count is unchanged and the pointers advance modulo DEPTH. Non-power-of-2 DEPTH wraps explicitly from DEPTH-1 to 0.
- Empty FIFO with no push: it contributes no request.

## Timing
- Reset values:
  - All counts and pointers are 0; rr_ptr = 0; lock = 0.
  - l2c_ciu_cmplt = 0, stalls = 0, arb_idle = 1.
  - Data, resp, cp, sid and bank outputs are 0.
- Buffered latency: a push in cycle N is presentable in cycle N+1 (FIFO registered).
- l2c_ciu_* are combinational from the FIFO heads plus the registered lock/rr state. There is no combinational path from bankN_cmplt to the outputs, except as allowed under Configuration.
- bankN_resp_stall depends only on registered count (no input-to-output path).
- Reset asserted mid-transfer: all buffered responses are discarded immediately; outputs return to reset values asynchronously.

## Configuration
- L2C_RESP_BYPASS_EN defined: a bank's response bypasses its FIFO and is presented in the same cycle when all of the following hold:
  - both FIFOs are empty;
  - no lock is held;
  - exactly one bankN_cmplt is high;
  - ciu_l2c_resp_rdy is high.

  The bypassed response is accepted in that same cycle and is not written to the FIFO. rr_ptr updates as on a normal accept. If rdy is low, the response is written to the FIFO normally.
- Undefined: every response is buffered; minimum latency is 1 cycle.

## Test plan
- Single push: bank0 pushes sid=5'h03, resp=5'h01, rdy=1 -> cmplt in cycle N+1 with sid=03, bank=0, arb_idle high at N+2. With L2C_RESP_BYPASS_EN, cmplt is in cycle N.
- Fairness: both banks hold 3 entries, rdy=1 -> outputs alternate bank 0,1,0,1,0,1 starting from rr_ptr=0; six accepts in six cycles.
- Backpressure lock: rdy=0 for 5 cycles with both banks non-empty -> outputs (bank, sid, data) hold stable; on rdy=1 that response pops and the other bank follows.
- Stall threshold: DEPTH=4, PIPE_LAT=2, rdy=0, bank1 pushes 2 -> bank1_resp_stall rises the cycle after the 2nd push. Two further pushes fill to 4 without overflow.
- Wrap with simultaneous push and pop: DEPTH=3, continuous push and pop on bank0 for 10 cycles with rdy=1 -> sid order is preserved and count stays constant.
- Reset mid-operation: cpurst_b low with 2 entries per bank -> cmplt=0, arb_idle=1 immediately; no stale response after reset release.
